// File: rtl/scan_texture_loader.sv
// -----------------------------------------------------------------------------
// scan_texture_loader
//
// Receives serial frames on a two-phase scan port (phi1/phi2 strobes, serial
// data, latch) that is asynchronous to clk. Each committed frame becomes one
// valid/ready write into texture memory. The loader supports a single-write
// mode and an auto-increment burst mode, and reports malformed frames and
// overruns through sticky error flags.
//
// Frame layout (MSB first): mode bit, ADDR_W address bits, DATA_W data bits.
// While in burst mode, each frame carries DATA_W data bits only. A latch with
// no bits leaves burst mode.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   scan_phi1    phase-1 strobe (checked only; must be low at phi2 rise)
//   scan_phi2    phase-2 strobe; rising edge shifts in scan_data
//   scan_data    serial data, MSB first
//   scan_latch   rising edge commits the frame
//   wr_valid     write request
//   wr_ready     memory accepts the write
//   wr_addr      write address
//   wr_data      write data
//   burst_active burst mode engaged
//   frame_err    sticky: illegal bit count or phase violation at commit
//   overrun_err  sticky: commit arrived while a write was stalled
//   err_clr      clears both sticky flags
//   load_count   number of accepted writes (wraps)
// -----------------------------------------------------------------------------
module scan_texture_loader #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_phi1,
  input  logic              scan_phi2,
  input  logic              scan_data,
  input  logic              scan_latch,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              burst_active,
  output logic              frame_err,
  output logic              overrun_err,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  load_count
);

  localparam int FRAME_N = 1 + ADDR_W + DATA_W;
  localparam int BCNT_W  = $clog2(FRAME_N + 2);
  localparam int SS      = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [BCNT_W-1:0] CNT_ZERO = {BCNT_W{1'b0}};
  localparam logic [BCNT_W-1:0] CNT_DATA = BCNT_W'(DATA_W);
  localparam logic [BCNT_W-1:0] CNT_FULL = BCNT_W'(FRAME_N);
  localparam logic [BCNT_W-1:0] CNT_OVER = BCNT_W'(FRAME_N + 1);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_BURST  = 1'b1;

  // Synchroniser chains; the last stage is the clk-domain view of each pin.
  logic [SS-1:0] phi1_sync_r;
  logic [SS-1:0] phi2_sync_r;
  logic [SS-1:0] data_sync_r;
  logic [SS-1:0] latch_sync_r;
  logic          phi2_hist_r;
  logic          latch_hist_r;

  logic [FRAME_N-1:0] shreg_r;
  logic [BCNT_W-1:0]  cnt_r;
  logic               phase_bad_r;
  logic [0:0]         state_r;
  logic [ADDR_W-1:0]  burst_addr_r;
  logic               wr_valid_r;
  logic [ADDR_W-1:0]  wr_addr_r;
  logic [DATA_W-1:0]  wr_data_r;
  logic               frame_err_r;
  logic               overrun_err_r;
  logic [CNT_W-1:0]   load_count_r;

  logic               phi2_rise_s;
  logic               latch_rise_s;
  logic [FRAME_N-1:0] shreg_nx_s;
  logic [BCNT_W-1:0]  cnt_nx_s;
  logic               phase_bad_nx_s;
  logic               accept_s;
  logic               can_load_s;
  logic               do_write_s;
  logic [ADDR_W-1:0]  wr_addr_nx_s;
  logic [DATA_W-1:0]  wr_data_nx_s;
  logic [0:0]         state_nx_s;
  logic [ADDR_W-1:0]  burst_addr_nx_s;
  logic [ADDR_W-1:0]  burst_addr_inc_s;
  logic               frame_err_set_s;
  logic               overrun_set_s;

  assign wr_valid     = wr_valid_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign burst_active = (state_r == ST_BURST);
  assign frame_err    = frame_err_r;
  assign overrun_err  = overrun_err_r;
  assign load_count   = load_count_r;

  // Input synchronisers and edge-detect history flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phi1_sync_r  <= {SS{1'b0}};
      phi2_sync_r  <= {SS{1'b0}};
      data_sync_r  <= {SS{1'b0}};
      latch_sync_r <= {SS{1'b0}};
      phi2_hist_r  <= 1'b0;
      latch_hist_r <= 1'b0;
    end else begin
      phi1_sync_r  <= {phi1_sync_r[SS-2:0], scan_phi1};
      phi2_sync_r  <= {phi2_sync_r[SS-2:0], scan_phi2};
      data_sync_r  <= {data_sync_r[SS-2:0], scan_data};
      latch_sync_r <= {latch_sync_r[SS-2:0], scan_latch};
      phi2_hist_r  <= phi2_sync_r[SS-1];
      latch_hist_r <= latch_sync_r[SS-1];
    end
  end

  // Shift/count update; computed before commit so a same-cycle phi2 edge
  // is included in the bit count that the latch evaluates.
  always_comb begin
    phi2_rise_s    = phi2_sync_r[SS-1] & ~phi2_hist_r;
    shreg_nx_s     = shreg_r;
    cnt_nx_s       = cnt_r;
    phase_bad_nx_s = phase_bad_r;
    if (phi2_rise_s) begin
      // Bits past a full frame do not disturb the captured payload.
      if (cnt_r < CNT_FULL) begin
        shreg_nx_s = {shreg_r[FRAME_N-2:0], data_sync_r[SS-1]};
      end else begin
        shreg_nx_s = shreg_r;
      end
      // Saturate one past legal so an over-long frame stays illegal.
      if (cnt_r < CNT_OVER) begin
        cnt_nx_s = cnt_r + BCNT_W'(1);
      end else begin
        cnt_nx_s = cnt_r;
      end
      if (phi1_sync_r[SS-1]) begin
        phase_bad_nx_s = 1'b1;
      end else begin
        phase_bad_nx_s = phase_bad_r;
      end
    end else begin
      shreg_nx_s     = shreg_r;
      cnt_nx_s       = cnt_r;
      phase_bad_nx_s = phase_bad_r;
    end
  end

  // Commit decision on a latch edge: write, burst entry/exit, or error.
  always_comb begin
    latch_rise_s     = latch_sync_r[SS-1] & ~latch_hist_r;
    accept_s         = wr_valid_r & wr_ready;
    can_load_s       = ~wr_valid_r | wr_ready;
    burst_addr_inc_s = burst_addr_r + ADDR_W'(1);
    do_write_s       = 1'b0;
    wr_addr_nx_s     = wr_addr_r;
    wr_data_nx_s     = wr_data_r;
    state_nx_s       = state_r;
    burst_addr_nx_s  = burst_addr_r;
    frame_err_set_s  = 1'b0;
    overrun_set_s    = 1'b0;
    if (latch_rise_s) begin
      if (!can_load_s) begin
        // Stalled write is kept; the new frame is lost.
        overrun_set_s = 1'b1;
      end else if (state_r == ST_NORMAL) begin
        if ((cnt_nx_s == CNT_FULL) && !phase_bad_nx_s) begin
          do_write_s   = 1'b1;
          wr_addr_nx_s = shreg_nx_s[FRAME_N-2:DATA_W];
          wr_data_nx_s = shreg_nx_s[DATA_W-1:0];
          if (shreg_nx_s[FRAME_N-1]) begin
            state_nx_s      = ST_BURST;
            burst_addr_nx_s = shreg_nx_s[FRAME_N-2:DATA_W];
          end else begin
            state_nx_s      = ST_NORMAL;
            burst_addr_nx_s = burst_addr_r;
          end
        end else begin
          frame_err_set_s = 1'b1;
        end
      end else begin
        if ((cnt_nx_s == CNT_DATA) && !phase_bad_nx_s) begin
          do_write_s      = 1'b1;
          wr_addr_nx_s    = burst_addr_inc_s;
          wr_data_nx_s    = shreg_nx_s[DATA_W-1:0];
          burst_addr_nx_s = burst_addr_inc_s;
        end else if (cnt_nx_s == CNT_ZERO) begin
          state_nx_s = ST_NORMAL;
        end else begin
          frame_err_set_s = 1'b1;
        end
      end
    end else begin
      do_write_s = 1'b0;
    end
  end

  // Frame state, write handshake, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_r       <= {FRAME_N{1'b0}};
      cnt_r         <= CNT_ZERO;
      phase_bad_r   <= 1'b0;
      state_r       <= ST_NORMAL;
      burst_addr_r  <= {ADDR_W{1'b0}};
      wr_valid_r    <= 1'b0;
      wr_addr_r     <= {ADDR_W{1'b0}};
      wr_data_r     <= {DATA_W{1'b0}};
      frame_err_r   <= 1'b0;
      overrun_err_r <= 1'b0;
      load_count_r  <= {CNT_W{1'b0}};
    end else begin
      shreg_r <= shreg_nx_s;
      if (latch_rise_s) begin
        cnt_r       <= CNT_ZERO;
        phase_bad_r <= 1'b0;
      end else begin
        cnt_r       <= cnt_nx_s;
        phase_bad_r <= phase_bad_nx_s;
      end
      state_r      <= state_nx_s;
      burst_addr_r <= burst_addr_nx_s;
      if (do_write_s) begin
        wr_valid_r <= 1'b1;
        wr_addr_r  <= wr_addr_nx_s;
        wr_data_r  <= wr_data_nx_s;
      end else if (accept_s) begin
        wr_valid_r <= 1'b0;
      end else begin
        wr_valid_r <= wr_valid_r;
      end
      if (accept_s) begin
        load_count_r <= load_count_r + CNT_W'(1);
      end else begin
        load_count_r <= load_count_r;
      end
      // A new error outranks a simultaneous clear.
      if (frame_err_set_s) begin
        frame_err_r <= 1'b1;
      end else if (err_clr) begin
        frame_err_r <= 1'b0;
      end else begin
        frame_err_r <= frame_err_r;
      end
      if (overrun_set_s) begin
        overrun_err_r <= 1'b1;
      end else if (err_clr) begin
        overrun_err_r <= 1'b0;
      end else begin
        overrun_err_r <= overrun_err_r;
      end
    end
  end

endmodule

// File: tb/tb_scan_texture_loader.sv
// -----------------------------------------------------------------------------
// tb_scan_texture_loader
//
// Directed bench for scan_texture_loader with default parameters
// (ADDR_W=11, DATA_W=8, SYNC_STAGES=2, CNT_W=16). Scan pins are driven slowly
// relative to clk; accepted writes are captured by a monitor and compared
// with hand-computed addresses and data.
// -----------------------------------------------------------------------------
module tb_scan_texture_loader;

  logic        clk;
  logic        rst_n;
  logic        scan_phi1;
  logic        scan_phi2;
  logic        scan_data;
  logic        scan_latch;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        burst_active;
  logic        frame_err;
  logic        overrun_err;
  logic        err_clr;
  logic [15:0] load_count;

  int errors = 0;
  int checks = 0;

  int          wr_cnt = 0;
  logic [10:0] cap_addr [0:63];
  logic [7:0]  cap_data [0:63];
  int          base;

  scan_texture_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_phi1    (scan_phi1),
    .scan_phi2    (scan_phi2),
    .scan_data    (scan_data),
    .scan_latch   (scan_latch),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .burst_active (burst_active),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err),
    .err_clr      (err_clr),
    .load_count   (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted write.
  always @(posedge clk) begin
    if (rst_n && wr_valid && wr_ready) begin
      cap_addr[wr_cnt] <= wr_addr;
      cap_data[wr_cnt] <= wr_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    clks(1);
  endtask

  task automatic shift_bit(input logic b, input logic p1);
    scan_data = b;
    scan_phi1 = p1;
    clks(4);
    scan_phi2 = 1'b1;
    clks(4);
    scan_phi2 = 1'b0;
    scan_phi1 = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] val, input int nbits, input int bad_idx);
    for (int i = nbits - 1; i >= 0; i--) begin
      shift_bit(val[i], (i == bad_idx));
    end
    clks(4);
  endtask

  task automatic do_latch();
    scan_latch = 1'b1;
    clks(6);
    scan_latch = 1'b0;
    clks(4);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, wr_valid}, 32'd0);
    chk({tag, "_addr"}, {21'd0, wr_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, wr_data}, 32'd0);
    chk({tag, "_burst"}, {31'd0, burst_active}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_oerr"}, {31'd0, overrun_err}, 32'd0);
    chk({tag, "_cnt"}, {16'd0, load_count}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    scan_phi1  = 1'b0;
    scan_phi2  = 1'b0;
    scan_data  = 1'b0;
    scan_latch = 1'b0;
    wr_ready   = 1'b1;
    err_clr    = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(1);
    chk_idle("reset");

    // Single write; check synchroniser latency of latch -> wr_valid.
    base = wr_cnt;
    send_frame({12'd0, 1'b0, 11'h2A5, 8'hC3}, 20, -1);
    scan_latch = 1'b1;
    clks(1);
    chk("lat_edge1", {31'd0, wr_valid}, 32'd0);
    clks(1);
    chk("lat_edge2", {31'd0, wr_valid}, 32'd0);
    clks(1);
    chk("lat_edge3", {31'd0, wr_valid}, 32'd1);
    chk("single_addr", {21'd0, wr_addr}, 32'h2A5);
    chk("single_data", {24'd0, wr_data}, 32'hC3);
    clks(5);
    scan_latch = 1'b0;
    clks(4);
    chk("single_valid_drop", {31'd0, wr_valid}, 32'd0);
    chk("single_count", {16'd0, load_count}, 32'd1);
    chk("single_writes", wr_cnt - base, 32'd1);
    chk("single_ferr", {31'd0, frame_err}, 32'd0);
    chk("single_oerr", {31'd0, overrun_err}, 32'd0);

    // Burst with address wrap, then zero-bit latch to exit.
    do_reset();
    base = wr_cnt;
    send_frame({12'd0, 1'b1, 11'h7FE, 8'h11}, 20, -1);
    do_latch();
    chk("burst_on", {31'd0, burst_active}, 32'd1);
    send_frame(32'h22, 8, -1);
    do_latch();
    send_frame(32'h33, 8, -1);
    do_latch();
    chk("burst_still_on", {31'd0, burst_active}, 32'd1);
    do_latch();
    chk("burst_off", {31'd0, burst_active}, 32'd0);
    chk("burst_count", {16'd0, load_count}, 32'd3);
    chk("burst_writes", wr_cnt - base, 32'd3);
    chk("burst_a0", {21'd0, cap_addr[base]}, 32'h7FE);
    chk("burst_d0", {24'd0, cap_data[base]}, 32'h11);
    chk("burst_a1", {21'd0, cap_addr[base+1]}, 32'h7FF);
    chk("burst_d1", {24'd0, cap_data[base+1]}, 32'h22);
    chk("burst_a2", {21'd0, cap_addr[base+2]}, 32'h000);
    chk("burst_d2", {24'd0, cap_data[base+2]}, 32'h33);
    chk("burst_ferr", {31'd0, frame_err}, 32'd0);

    // Illegal counts in normal and burst state; err_clr.
    do_reset();
    base = wr_cnt;
    send_frame({13'd0, 11'h155, 8'h0F}, 19, -1);
    do_latch();
    chk("short_ferr", {31'd0, frame_err}, 32'd1);
    chk("short_burst", {31'd0, burst_active}, 32'd0);
    chk("short_count", {16'd0, load_count}, 32'd0);
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    chk("clr_ferr", {31'd0, frame_err}, 32'd0);
    send_frame({12'd0, 1'b1, 11'h100, 8'h55}, 20, -1);
    do_latch();
    chk("berr_enter", {31'd0, burst_active}, 32'd1);
    send_frame(32'h15, 5, -1);
    do_latch();
    chk("berr_ferr", {31'd0, frame_err}, 32'd1);
    chk("berr_burst", {31'd0, burst_active}, 32'd1);
    chk("berr_count", {16'd0, load_count}, 32'd1);
    chk("berr_writes", wr_cnt - base, 32'd1);
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    chk("clr_ferr2", {31'd0, frame_err}, 32'd0);
    do_latch();
    chk("berr_exit", {31'd0, burst_active}, 32'd0);

    // Overrun: second commit while first write is stalled.
    do_reset();
    base = wr_cnt;
    wr_ready = 1'b0;
    send_frame({12'd0, 1'b0, 11'h123, 8'hAB}, 20, -1);
    do_latch();
    chk("ovr_valid", {31'd0, wr_valid}, 32'd1);
    send_frame({12'd0, 1'b0, 11'h456, 8'hCD}, 20, -1);
    do_latch();
    chk("ovr_oerr", {31'd0, overrun_err}, 32'd1);
    chk("ovr_hold_addr", {21'd0, wr_addr}, 32'h123);
    chk("ovr_hold_data", {24'd0, wr_data}, 32'hAB);
    wr_ready = 1'b1;
    clks(4);
    chk("ovr_valid_drop", {31'd0, wr_valid}, 32'd0);
    chk("ovr_count", {16'd0, load_count}, 32'd1);
    chk("ovr_writes", wr_cnt - base, 32'd1);
    chk("ovr_cap_addr", {21'd0, cap_addr[base]}, 32'h123);

    // phi1 high during one phi2 rise.
    do_reset();
    base = wr_cnt;
    send_frame({12'd0, 1'b0, 11'h0F0, 8'h3C}, 20, 7);
    do_latch();
    chk("phi1_ferr", {31'd0, frame_err}, 32'd1);
    chk("phi1_count", {16'd0, load_count}, 32'd0);
    chk("phi1_writes", wr_cnt - base, 32'd0);

    // Reset mid-frame with a pending write, then a clean frame.
    do_reset();
    wr_ready = 1'b0;
    send_frame({12'd0, 1'b0, 11'h111, 8'h22}, 20, -1);
    do_latch();
    chk("mid_pending", {31'd0, wr_valid}, 32'd1);
    send_frame(32'h3FF, 10, -1);
    do_reset();
    chk_idle("midrst");
    base = wr_cnt;
    wr_ready = 1'b1;
    send_frame({12'd0, 1'b0, 11'h3C3, 8'h5A}, 20, -1);
    do_latch();
    chk("post_writes", wr_cnt - base, 32'd1);
    chk("post_addr", {21'd0, cap_addr[base]}, 32'h3C3);
    chk("post_data", {24'd0, cap_data[base]}, 32'h5A);
    chk("post_count", {16'd0, load_count}, 32'd1);
    chk("post_ferr", {31'd0, frame_err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_texture_loader.md
Name: scan_texture_loader

Overview:
- Parametrised successor to the GPU's single-format texture scan port.
- Receives serial frames on a two-phase scan interface (phi1/phi2 strobes, serial data, latch), all sampled in the `clk` domain through synchronisers.
- Turns each frame into a valid/ready write to texture memory. Adds configurable address/data widths, an auto-increment burst mode, and sticky error reporting for malformed frames and overruns.

Parameters:
- ADDR_W, 11, texture address width in bits.
- DATA_W, 8, texture data width in bits.
- SYNC_STAGES, 2, flops per input synchroniser (minimum 2).
- CNT_W, 16, width of the committed-write counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- scan_phi1  in  1  phase-1 strobe, asynchronous to clk.
- scan_phi2  in  1  phase-2 strobe, asynchronous to clk; its rising edge shifts in one bit.
- scan_data  in  1  serial data, MSB first.
- scan_latch  in  1  frame commit strobe; its rising edge commits the frame.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- burst_active  out  1  burst mode is engaged.
- frame_err  out  1  sticky: latch arrived with an illegal bit count.
- overrun_err  out  1  sticky: latch arrived while wr_valid was pending.
- err_clr  in  1  clears both sticky flags.
- load_count  out  CNT_W  number of accepted writes.

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs go to 0; the shift register, bit counter, burst address and synchronisers also clear. Reset mid-frame discards the partial frame and any pending write.
- Synchronisers: scan_phi1, scan_phi2, scan_data and scan_latch each pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - A phi2 rise shifts in the synchronised scan_data.
  - phi1 is only checked: a phi2 rise while synchronised phi1=1 counts as a frame error at commit.
- Normal frame: 1 mode bit, then ADDR_W address bits, then DATA_W data bits, MSB first. The legal count is N=1+ADDR_W+DATA_W.
  - The bit counter saturates at N+1.
  - Bits beyond N are ignored for data, but the frame is then illegal.
- Latch edge in normal state:
  - count==N, mode=0: single write to the shifted address.
  - count==N, mode=1: write, then burst_active=1 and the burst address is set to the shifted address.
  - Any other count: frame_err=1, no write.
  - The counter clears in every case.
- Burst state, on a latch edge:
  - count==DATA_W: write the data to burst address+1. The address wraps modulo 2^ADDR_W, and the burst address updates to it.
  - count==0: exit burst (burst_active=0), no write, no error.
  - Any other count: frame_err=1, burst stays active, no write.
- Write handshake:
  - wr_valid rises on the clk edge after the edge-detect cycle. Latency from a scan_latch pin rise to wr_valid is SYNC_STAGES+1 clk edges.
  - wr_addr and wr_data are stable while wr_valid=1.
  - The write completes on the edge where wr_valid && wr_ready; wr_valid drops on that edge unless a new commit is loaded the same cycle.
  - load_count increments on each completed write and wraps at 2^CNT_W.
- Simultaneous events:
  - Latch edge while wr_valid=1 and wr_ready=0: the new frame is dropped, overrun_err=1, and the pending write is kept.
  - Latch edge in the same cycle as an accepting handshake: the old write completes and the new one is loaded; wr_valid stays high.
  - A phi2 edge and a latch edge in the same cycle: the shift is applied first, then the count is evaluated.
  - err_clr in the same cycle as a new error: the error wins and the flag stays set.
- The shift register keeps shifting while a write is pending. Only the commit is blocked.

Test Plan:
- Normal frame, 20 bits, mode=0, addr=0x2A5, data=0xC3, then latch, wr_ready=1 -> one write addr=0x2A5 data=0xC3; wr_valid rises 3 clks after the latch pin rise (SYNC_STAGES=2); load_count=1; no errors.
- Burst: mode=1 frame addr=0x7FE data=0x11, then 8-bit frames 0x22 and 0x33, then a 0-bit latch -> writes (0x7FE,0x11), (0x7FF,0x22), (0x000,0x33); burst_active falls after the final latch; load_count=3.
- Latch after 19 bits in normal state, then latch after 5 bits in burst state -> frame_err=1 each time, no write, burst_active unchanged; err_clr clears frame_err the next cycle.
- wr_ready=0, two legal frames committed -> first write held; second dropped; overrun_err=1; raising wr_ready completes only the first; load_count=1.
- Frame shifted with phi1 held high on one phi2 rise -> frame_err=1, no write.
- rst_n=0 for 1 clk after 10 bits shifted with a pending write -> all outputs 0; a following legal 20-bit frame writes correctly.
